// File: rtl/ram_io_pkg.sv
// rtl/ram_io_pkg.sv - shared constants and request type for the RAM_IO BRAM port
package ram_io_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 3;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
`ifdef RAM_IO_BYTE_EN_EN
    logic [DATA_W_DEF/8-1:0] be;
`endif
  } ram_req_t;

endpackage

// File: rtl/ram_io_rsp_fifo.sv
// rtl/ram_io_rsp_fifo.sv - synchronous response FIFO, power-of-two depth
module ram_io_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   UserCLK,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // At full with a simultaneous pop, wr_ptr equals rd_ptr; the head is read
  // combinationally before the edge overwrites it.
  always_ff @(posedge UserCLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_io_bram_port.sv
// rtl/ram_io_bram_port.sv - fabric request to BRAM port adapter with credit-gated read responses
// Optional byte enables: RAM_IO_BYTE_EN_EN.
module ram_io_bram_port
  import ram_io_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              UserCLK,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef RAM_IO_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] req_be,
  output logic [DATA_W/8-1:0] mem_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_io_bram_port: RD_LAT out of range");
  end

  logic              accept;
  logic              rd_accept;
  logic              wr_effective;
  logic              pop;
  logic              push;
  logic              rd_issue;
  logic [RD_LAT-1:0] rd_pipe;
  logic [CW-1:0]     credit;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Ready depends only on registered credit so the fabric never sees a
  // combinational path from req_valid.
  assign req_ready = (credit < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rd_pipe[RD_LAT-1];
  assign rsp_valid = !fifo_empty;

`ifdef RAM_IO_BYTE_EN_EN
  assign wr_effective = req_we && (req_be != '0);
`else
  assign wr_effective = req_we;
`endif

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_issue  <= 1'b0;
`ifdef RAM_IO_BYTE_EN_EN
      mem_be    <= '0;
`endif
    end else begin
      mem_en   <= accept;
      mem_we   <= accept && wr_effective;
      rd_issue <= rd_accept;
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
`ifdef RAM_IO_BYTE_EN_EN
        mem_be    <= req_be;
`endif
      end
    end
  end

  // rd_pipe[k] marks a read whose BRAM data lands k+1 cycles after mem_en.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      credit <= '0;
    end else if (rd_accept && !pop) begin
      credit <= credit + CW'(1);
    end else if (!rd_accept && pop) begin
      credit <= credit - CW'(1);
    end
  end

  ram_io_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W)
  ) u_rsp_fifo (
    .UserCLK   (UserCLK),
    .rst       (rst),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop),
    .pop_data  (rsp_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge UserCLK) begin
    if (!rst) begin
      assert (!(push && fifo_full && !pop));
      assert (fifo_count <= credit);
    end
  end

endmodule
